// File: rtl/cpu_dmareq_pkg.sv
// Shared types and default parameters for the CPU DMA request hubs.
package cpu_dmareq_pkg;

   localparam int unsigned DefNreq  = 4;
   localparam int unsigned DefSync  = 2;
   localparam int unsigned DefClrTo = 64;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StActive,
      StClear
   } hub_state_e;

endpackage

// File: rtl/cpu_dmareq_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps modulo NREQ.
module cpu_dmareq_rr_arb #(
   parameter int unsigned NREQ = 4,
   localparam int unsigned SELW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [SELW-1:0] idx,
   output logic            any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         j = (int'(ptr) + k) % int'(NREQ);
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = SELW'(j);
         end
      end
   end

endmodule

// File: rtl/cpu_dmareq_hub.sv
// DMA request hub: synchronises per-requester sreq/breq, arbitrates round-robin onto one
// DMA channel, and runs the clear handshake back to the granted requester.
module cpu_dmareq_hub
   import cpu_dmareq_pkg::*;
#(
   parameter int unsigned NREQ   = DefNreq,
   parameter int unsigned SYNC   = DefSync,
   parameter int unsigned CLR_TO = DefClrTo,
   localparam int unsigned SELW  = $clog2(NREQ)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [NREQ-1:0] i_en,
   input  logic [NREQ-1:0] i_sreq,
   input  logic [NREQ-1:0] i_breq,
   output logic [NREQ-1:0] o_clr,
   output logic            o_dma_req,
   output logic            o_dma_burst,
   output logic [SELW-1:0] o_dma_sel,
   input  logic            i_dma_ack,
   input  logic            i_dma_done,
   output logic            o_busy,
   output logic            o_err,
   input  logic            i_err_clr
);

   localparam int unsigned CW = $clog2(CLR_TO + 1);

   logic [NREQ-1:0] s_sreq, s_breq, pend;
   logic [NREQ-1:0] arb_gnt;
   logic [SELW-1:0] arb_idx;
   logic            arb_any;

   hub_state_e      state_q, state_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic            burst_q, burst_d;
   logic [NREQ-1:0] clr_q, clr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d, err_set;

   if (SYNC == 0) begin : g_nosync
      assign s_sreq = i_sreq;
      assign s_breq = i_breq;
   end else begin : g_sync
      logic [NREQ-1:0] sreq_ff [SYNC];
      logic [NREQ-1:0] breq_ff [SYNC];

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            for (int i = 0; i < int'(SYNC); i++) begin
               sreq_ff[i] <= '0;
               breq_ff[i] <= '0;
            end
         end else begin
            sreq_ff[0] <= i_sreq;
            breq_ff[0] <= i_breq;
            for (int i = 1; i < int'(SYNC); i++) begin
               sreq_ff[i] <= sreq_ff[i-1];
               breq_ff[i] <= breq_ff[i-1];
            end
         end
      end

      assign s_sreq = sreq_ff[SYNC-1];
      assign s_breq = breq_ff[SYNC-1];
   end

   // A requester still being cleared must not be re-granted.
   assign pend = (s_sreq | s_breq) & i_en & ~clr_q;

   cpu_dmareq_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .req (pend),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      clr_d   = clr_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;

      if (i_dma_done && (state_q != StActive)) err_set = 1'b1;
      if (i_dma_ack && (state_q != StGrant)) err_set = 1'b1;

      case (state_q)
         StIdle: begin
            if (arb_any) begin
               sel_d   = arb_idx;
               burst_d = |(s_breq & arb_gnt);
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (i_dma_ack) begin
               ptr_d   = sel_q;
               state_d = StActive;
            end
         end
         StActive: begin
            if (i_dma_done) begin
               clr_d[sel_q] = 1'b1;
               cnt_d        = '0;
               state_d      = StClear;
            end
         end
         StClear: begin
            if (!s_sreq[sel_q] && !s_breq[sel_q]) begin
               clr_d   = '0;
               state_d = StIdle;
            end else if (cnt_q == CW'(CLR_TO - 1)) begin
               clr_d   = '0;
               err_set = 1'b1;
               state_d = StIdle;
            end else if (cnt_q != CW'(CLR_TO)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      err_d = err_set | (err_q & ~i_err_clr);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         ptr_q   <= SELW'(NREQ - 1);
         burst_q <= 1'b0;
         clr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
         clr_q   <= clr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Handshake outputs are masked by reset so they fall in the reset cycle itself.
   assign o_clr       = i_rst ? '0 : clr_q;
   assign o_dma_req   = (state_q == StGrant) & ~i_rst;
   assign o_dma_burst = burst_q;
   assign o_dma_sel   = sel_q;
   assign o_busy      = (state_q != StIdle);
   assign o_err       = err_q;

endmodule

// File: tb/tb_cpu_dmareq_hub.sv
// Directed bench for cpu_dmareq_hub (NREQ=4, SYNC=2, CLR_TO=8).
module tb_cpu_dmareq_hub;

   logic       clk;
   logic       rst;
   logic [3:0] en, sreq, breq;
   logic [3:0] clr;
   logic       dma_req, dma_burst, dma_ack, dma_done;
   logic [1:0] dma_sel;
   logic       busy, err, err_clr;

   int checks = 0;
   int errors = 0;

   int rr_sel[5]   = '{0, 1, 2, 3, 0};
   int rr_burst[5] = '{0, 1, 0, 0, 0};
   int en_sel[4]   = '{1, 3, 0, 1};

   cpu_dmareq_hub #(
      .NREQ   (4),
      .SYNC   (2),
      .CLR_TO (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_sreq      (sreq),
      .i_breq      (breq),
      .o_clr       (clr),
      .o_dma_req   (dma_req),
      .o_dma_burst (dma_burst),
      .o_dma_sel   (dma_sel),
      .i_dma_ack   (dma_ack),
      .i_dma_done  (dma_done),
      .o_busy      (busy),
      .o_err       (err),
      .i_err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int max, output bit ok);
      int n = 0;
      while (!dma_req && n < max) begin
         tick();
         n++;
      end
      ok = dma_req;
   endtask

   task automatic wait_clr_low(input int max, output bit ok);
      int n = 0;
      while (clr != 4'b0 && n < max) begin
         tick();
         n++;
      end
      ok = (clr == 4'b0);
   endtask

   // One full grant/ack/done/clear handshake; the winner (or everyone) drops at ack.
   task automatic xact(input int w, input bit burst_exp, input bit drop_all);
      bit ok;
      wait_req(20, ok);
      chk("req_seen", 32'(ok), 1);
      chk("sel", 32'(dma_sel), 32'(w));
      chk("burst", 32'(dma_burst), 32'(burst_exp));
      dma_ack = 1'b1;
      if (drop_all) begin
         sreq = '0;
         breq = '0;
      end else begin
         sreq[w] = 1'b0;
         breq[w] = 1'b0;
      end
      tick();
      dma_ack = 1'b0;
      chk("active_req_low", 32'(dma_req), 0);
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("clr_set", 32'(clr), 32'(1) << w);
      wait_clr_low(20, ok);
      chk("clr_drop", 32'(ok), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst = 1'b1; en = 4'hF; sreq = 4'hF; breq = 4'h0;
      dma_ack = 1'b0; dma_done = 1'b0; err_clr = 1'b0;

      // 1: reset with everything requesting, then first grant latency
      tick(); tick();
      chk("rst_req", 32'(dma_req), 0);
      chk("rst_clr", 32'(clr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_sel", 32'(dma_sel), 0);
      chk("rst_burst", 32'(dma_burst), 0);
      rst = 1'b0;
      tick(); tick();
      chk("lat_early", 32'(dma_req), 0);
      tick();
      chk("lat_req", 32'(dma_req), 1);
      chk("lat_sel", 32'(dma_sel), 0);
      dma_ack = 1'b1; sreq = 4'h0;
      tick();
      dma_ack = 1'b0; dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t1_clr", 32'(clr), 32'h1);
      tick();
      chk("t1_clr_drop", 32'(clr), 0);
      chk("t1_idle", 32'(busy), 0);

      // 2: single request on requester 2
      sreq = 4'b0100;
      tick(); tick(); tick();
      chk("t2_req", 32'(dma_req), 1);
      chk("t2_sel", 32'(dma_sel), 2);
      chk("t2_burst", 32'(dma_burst), 0);
      dma_ack = 1'b1;
      tick();
      dma_ack = 1'b0;
      chk("t2_act_req", 32'(dma_req), 0);
      chk("t2_act_busy", 32'(busy), 1);
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t2_clr", 32'(clr), 32'h4);
      tick();
      chk("t2_clr_hold", 32'(clr), 32'h4);
      sreq = 4'b0000;
      tick(); tick();
      chk("t2_clr_lag", 32'(clr), 32'h4);
      tick();
      chk("t2_clr_drop", 32'(clr), 0);
      chk("t2_idle", 32'(busy), 0);

      // 3: round-robin with reset pointer; requester 1 asserts both sreq and breq
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sreq = 4'hF; breq = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         xact(rr_sel[i], rr_sel[i] == 1, i == 4);
         if (i < 4) begin
            sreq[rr_sel[i]] = 1'b1;
            if (rr_sel[i] == 1) breq[1] = 1'b1;
         end
      end
      tick(); tick();
      chk("t3_idle", 32'(busy), 0);
      chk("t3_err", 32'(err), 0);

      // 4: requester 2 disabled never wins; disabling mid-transaction does not abort
      en = 4'b1011; sreq = 4'hF;
      for (int i = 0; i < 4; i++) begin
         xact(en_sel[i], 1'b0, i == 3);
         if (i < 3) sreq[en_sel[i]] = 1'b1;
      end
      en = 4'b0001; sreq = 4'b0001;
      wait_req(20, ok);
      chk("t4_req_seen", 32'(ok), 1);
      chk("t4_sel0", 32'(dma_sel), 0);
      dma_ack = 1'b1;
      tick();
      dma_ack = 1'b0; en = 4'b0000; dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t4_clr_disabled", 32'(clr), 32'h1);
      sreq = 4'b0000;
      wait_clr_low(20, ok);
      chk("t4_clr_drop", 32'(ok), 1);
      chk("t4_err", 32'(err), 0);
      en = 4'hF;

      // 5: requester 3 never drops during clear -> timeout after 8 cycles
      sreq = 4'b1000;
      wait_req(20, ok);
      chk("t5_req_seen", 32'(ok), 1);
      chk("t5_sel", 32'(dma_sel), 3);
      dma_ack = 1'b1;
      tick();
      dma_ack = 1'b0; dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t5_clr_c0", 32'(clr), 32'h8);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("t5_clr_held", 32'(clr), 32'h8);
         if (i == 6) sreq = 4'b0000;
      end
      chk("t5_err_before", 32'(err), 0);
      tick();
      chk("t5_clr_timeout", 32'(clr), 0);
      chk("t5_err", 32'(err), 1);
      chk("t5_busy", 32'(busy), 0);
      tick();
      chk("t5_no_regrant", 32'(busy), 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t5_err_clr", 32'(err), 0);

      // 6: protocol errors
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t6_done_idle_err", 32'(err), 1);
      chk("t6_done_idle_busy", 32'(busy), 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t6_err_clr", 32'(err), 0);
      dma_ack = 1'b1;
      tick();
      dma_ack = 1'b0;
      chk("t6_ack_idle_err", 32'(err), 1);
      chk("t6_ack_idle_busy", 32'(busy), 0);
      dma_ack = 1'b1; err_clr = 1'b1;
      tick();
      dma_ack = 1'b0;
      chk("t6_err_wins", 32'(err), 1);
      tick();
      err_clr = 1'b0;
      chk("t6_err_clr2", 32'(err), 0);

      sreq = 4'b0001;
      wait_req(20, ok);
      chk("t6_req_seen", 32'(ok), 1);
      chk("t6_sel", 32'(dma_sel), 0);
      dma_ack = 1'b1; dma_done = 1'b1;
      tick();
      dma_ack = 1'b0; dma_done = 1'b0;
      chk("t6_ackdone_busy", 32'(busy), 1);
      chk("t6_ackdone_req", 32'(dma_req), 0);
      chk("t6_ackdone_err", 32'(err), 1);
      chk("t6_ackdone_clr", 32'(clr), 0);
      tick();
      chk("t6_still_active", 32'(clr), 0);
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t6_clr", 32'(clr), 32'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t6_err_clr3", 32'(err), 0);
      chk("t6_clr_hold", 32'(clr), 32'h1);

      rst = 1'b1; sreq = 4'b0000;
      #1;
      chk("t6_rst_clr_now", 32'(clr), 0);
      chk("t6_rst_req_now", 32'(dma_req), 0);
      tick();
      rst = 1'b0;
      chk("t6_rst_clr", 32'(clr), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_err", 32'(err), 0);
      tick();
      chk("t6_post_rst_idle", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
